display_7seg_scan: RTL and testbench
====================================

Name: display_7seg_scan

Overview:
- Parametrised successor to the fixed-value 7-segment encoder.
- Converts an arbitrary binary value, selected from the frequency or current input by `control`, into decimal with a sequential double-dabble converter.
- Drives an N-digit multiplexed common-anode display with leading-zero blanking and overflow indication.
- Sits between the frequency/current registers and the board display pins.

Parameters:
- DATA_W, 10: width of both value inputs.
- NUM_DIG, 4: number of display digits; digit 0 is the rightmost.
- SCAN_DIV, 1: clk_d cycles per digit; 1 advances the scan every clock.

Ports:
- clk_d, in, 1: single system clock; everything is rising-edge.
- reset, in, 1: synchronous, active-low reset.
- frecuencia, in, DATA_W: value shown when control=1.
- corriente, in, DATA_W: value shown when control=0.
- control, in, 1: mode select.
- codificacion, out, 8: active-low segments; bit7=dp, bit6..0=a..g.
- digito, out, NUM_DIG: one-hot, active-high digit enable.
- frame_done, out, 1: one-cycle pulse when a new value is committed to the display register.

Behaviour:
- Reset (reset=0 at a clk_d edge):
  - codificacion=8'hFF, digito=0, frame_done=0.
  - Scan index=0, prescaler=0, converter IDLE.
  - Display register holds value 0, shown as a lone "0" on digit 0.
- First scan: first digit is driven on the edge after reset returns high. digito=1, codificacion=8'b10000001.
- Converter FSM (in sub-module):
  - IDLE: load the mux(control) value into the shift register, clear BCD, go to SHIFT. MAX = 10^NUM_DIG−1; set ovf = (value > MAX).
  - SHIFT: DATA_W cycles. Each cycle add 3 to every BCD nibble ≥5, then shift left by 1.
  - DONE: one cycle. Commit BCD and ovf to the display register, pulse frame_done, return to IDLE.
- Conversion timing:
  - Snapshot-to-commit latency is DATA_W+2 cycles.
  - Conversions repeat back-to-back, so the shown value tracks its input within 2·(DATA_W+2) cycles.
  - Input changes during SHIFT are ignored until the next snapshot.
  - A `control` toggle takes effect at the next IDLE.
- BCD width: 4·NUM_DIG bits. Overflow is decided by the binary compare, not by BCD carry-out.
- Scan:
  - The prescaler counts 0..SCAN_DIV−1. On wrap, the scan index advances and wraps NUM_DIG−1 → 0.
  - digito = 1<<index and codificacion are registered together, so they never disagree for a cycle.
- Segment table (active-low a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - dp is always 1 (off).
- Leading-zero blanking: a digit above the most significant nonzero digit shows 8'hFF. Digit 0 is never blanked.
- Overflow: all digits show 8'b11111110 (g only), ovf having been latched at snapshot.
- Display register update:
  - Changes only at DONE, so a frame never mixes old and new digits.
  - If DONE coincides with a scan advance, the new digit uses the new value.
- Reset mid-conversion: conversion aborts, display returns to "0", no frame_done.

Decomposition:
- Shared package disp_pkg:
  - SEG_* digit constants 0–9.
  - SEG_BLANK=8'hFF, SEG_DASH=8'hFE.
  - Function pow10_minus1(NUM_DIG) giving MAX.
- One sub-module, bin2bcd_seq:
  - Parameters DATA_W, NUM_DIG.
  - Inputs clk_d, reset, din.
  - Outputs bcd, ovf, done.
- The top level holds the prescaler, scan index, display register and output decode.

Test Plan (DATA_W=10, NUM_DIG=4, SCAN_DIV=1 unless noted):
- Reset low 3 cycles then high, inputs 0 → digito 1,2,4,8 repeating; codificacion 10000001 then FF,FF,FF; frame_done first pulse 12 cycles after the first snapshot.
- control=1, frecuencia=125 → after frame_done, digits 0..3 = 10100100, 10010010, 11001111, 11111111.
- control=0, corriente=1000 → 10000001, 10000001, 10000001, 11001111; toggle control mid-SHIFT with frecuencia=7 → the current frame still shows 1000, the next frame shows 7 (10001111, FF, FF, FF).
- NUM_DIG=3, corriente=1023 → all three digits 11111110; then corriente=999 → 10000100 ×3.
- SCAN_DIV=4 → each digito value held exactly 4 cycles; digito and codificacion change on the same edge; no one-hot violation.
- reset=0 asserted 5 cycles into SHIFT with value 950 → next cycle codificacion=FF, digito=0; no frame_done; after release, "0" is displayed until the new conversion completes.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display path.
// Segment codes are active-low with bit7 = dp, bits 6..0 = a..g.
package disp_pkg;

    localparam logic [7:0] SEG_0     = 8'b1000_0001;
    localparam logic [7:0] SEG_1     = 8'b1100_1111;
    localparam logic [7:0] SEG_2     = 8'b1001_0010;
    localparam logic [7:0] SEG_3     = 8'b1000_0110;
    localparam logic [7:0] SEG_4     = 8'b1100_1100;
    localparam logic [7:0] SEG_5     = 8'b1010_0100;
    localparam logic [7:0] SEG_6     = 8'b1010_0000;
    localparam logic [7:0] SEG_7     = 8'b1000_1111;
    localparam logic [7:0] SEG_8     = 8'b1000_0000;
    localparam logic [7:0] SEG_9     = 8'b1000_0100;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hFE;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_DONE  = 2'd2
    } conv_state_e;

    // Largest value representable in n decimal digits.
    function automatic logic [31:0] pow10_minus1(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 32'd10;
        end
        return p - 32'd1;
    endfunction

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: snapshot, DATA_W shift cycles, one commit cycle.
// Overflow is judged on the binary snapshot so a truncated BCD result is never trusted.
module bin2bcd_seq
    import disp_pkg::*;
#(
    parameter int DATA_W  = 10,
    parameter int NUM_DIG = 4
) (
    input  logic                 clk_d,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    din,
    output logic [4*NUM_DIG-1:0] bcd,
    output logic                 ovf,
    output logic                 done
);

    localparam int          BCD_W = 4 * NUM_DIG;
    localparam int          CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [31:0] MAX_C = pow10_minus1(NUM_DIG);

    conv_state_e        state_r;
    logic [DATA_W-1:0]  bin_r;
    logic [BCD_W-1:0]   bcd_r;
    logic [BCD_W-1:0]   bcd_adj_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               ovf_snap_r;
    logic [BCD_W-1:0]   bcd_out_r;
    logic               ovf_out_r;
    logic               done_r;

    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Add-3 correction applied to the BCD field before each shift.
    always_comb begin
        bcd_adj_s = dabble_adj(bcd_r);
    end

    // Converter FSM with registered result, overflow flag and done pulse.
    always_ff @(posedge clk_d) begin
        if (!reset) begin
            state_r    <= CONV_IDLE;
            bin_r      <= {DATA_W{1'b0}};
            bcd_r      <= {BCD_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            ovf_snap_r <= 1'b0;
            bcd_out_r  <= {BCD_W{1'b0}};
            ovf_out_r  <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                CONV_IDLE: begin
                    bin_r      <= din;
                    bcd_r      <= {BCD_W{1'b0}};
                    cnt_r      <= {CNT_W{1'b0}};
                    ovf_snap_r <= (32'(din) > MAX_C);
                    state_r    <= CONV_SHIFT;
                end
                CONV_SHIFT: begin
                    {bcd_r, bin_r} <= {bcd_adj_s[BCD_W-2:0], bin_r, 1'b0};
                    if (cnt_r == CNT_W'(DATA_W - 1)) begin
                        state_r <= CONV_DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                CONV_DONE: begin
                    bcd_out_r <= bcd_r;
                    ovf_out_r <= ovf_snap_r;
                    done_r    <= 1'b1;
                    state_r   <= CONV_IDLE;
                end
                default: begin
                    state_r <= CONV_IDLE;
                end
            endcase
        end
    end

    assign bcd  = bcd_out_r;
    assign ovf  = ovf_out_r;
    assign done = done_r;

endmodule

// File: rtl/display_7seg_scan.sv
// N-digit multiplexed common-anode driver: value select, BCD conversion, display
// register, digit scan and segment decode with leading-zero blanking and overflow.
module display_7seg_scan
    import disp_pkg::*;
#(
    parameter int DATA_W   = 10,
    parameter int NUM_DIG  = 4,
    parameter int SCAN_DIV = 1
) (
    input  logic               clk_d,
    input  logic               reset,
    input  logic [DATA_W-1:0]  frecuencia,
    input  logic [DATA_W-1:0]  corriente,
    input  logic               control,
    output logic [7:0]         codificacion,
    output logic [NUM_DIG-1:0] digito,
    output logic               frame_done
);

    localparam int                 BCD_W   = 4 * NUM_DIG;
    localparam int                 IDX_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int                 PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [NUM_DIG-1:0] DIG_ONE = NUM_DIG'(1);

    logic [DATA_W-1:0]  sel_s;
    logic [BCD_W-1:0]   conv_bcd_s;
    logic               conv_ovf_s;
    logic               conv_done_s;
    logic [BCD_W-1:0]   disp_bcd_r;
    logic               disp_ovf_r;
    logic [BCD_W-1:0]   disp_bcd_next_s;
    logic               disp_ovf_next_s;
    logic [BCD_W-1:0]   upper_s;
    logic [3:0]         nib_s;
    logic [7:0]         seg_s;
    logic [NUM_DIG-1:0] dig_s;
    logic [IDX_W-1:0]   idx_r;
    logic [PRE_W-1:0]   pre_r;
    logic [7:0]         codificacion_r;
    logic [NUM_DIG-1:0] digito_r;
    logic               frame_done_r;

    // Source select; only sampled by the converter in its IDLE cycle.
    always_comb begin
        if (control) begin
            sel_s = frecuencia;
        end else begin
            sel_s = corriente;
        end
    end

    bin2bcd_seq #(
        .DATA_W  (DATA_W),
        .NUM_DIG (NUM_DIG)
    ) u_conv (
        .clk_d (clk_d),
        .reset (reset),
        .din   (sel_s),
        .bcd   (conv_bcd_s),
        .ovf   (conv_ovf_s),
        .done  (conv_done_s)
    );

    // Look through to the committing value so the digit driven on a commit edge is already new.
    always_comb begin
        if (conv_done_s) begin
            disp_bcd_next_s = conv_bcd_s;
            disp_ovf_next_s = conv_ovf_s;
        end else begin
            disp_bcd_next_s = disp_bcd_r;
            disp_ovf_next_s = disp_ovf_r;
        end
    end

    // Segment decode for the digit currently selected by the scan index.
    always_comb begin
        nib_s   = disp_bcd_next_s[{idx_r, 2'b00} +: 4];
        upper_s = disp_bcd_next_s >> {idx_r, 2'b00};
        dig_s   = DIG_ONE << idx_r;
        if (disp_ovf_next_s) begin
            seg_s = SEG_DASH;
        end else if ((idx_r != IDX_W'(0)) && (upper_s == {BCD_W{1'b0}})) begin
            seg_s = SEG_BLANK;
        end else begin
            seg_s = seg_of(nib_s);
        end
    end

    // Display register, scan prescaler/index and registered pin outputs.
    always_ff @(posedge clk_d) begin
        if (!reset) begin
            disp_bcd_r     <= {BCD_W{1'b0}};
            disp_ovf_r     <= 1'b0;
            idx_r          <= {IDX_W{1'b0}};
            pre_r          <= {PRE_W{1'b0}};
            codificacion_r <= SEG_BLANK;
            digito_r       <= {NUM_DIG{1'b0}};
            frame_done_r   <= 1'b0;
        end else begin
            disp_bcd_r     <= disp_bcd_next_s;
            disp_ovf_r     <= disp_ovf_next_s;
            frame_done_r   <= conv_done_s;
            codificacion_r <= seg_s;
            digito_r       <= dig_s;
            if (pre_r == PRE_W'(SCAN_DIV - 1)) begin
                pre_r <= {PRE_W{1'b0}};
                if (idx_r == IDX_W'(NUM_DIG - 1)) begin
                    idx_r <= {IDX_W{1'b0}};
                end else begin
                    idx_r <= idx_r + IDX_W'(1);
                end
            end else begin
                pre_r <= pre_r + PRE_W'(1);
            end
        end
    end

    assign codificacion = codificacion_r;
    assign digito       = digito_r;
    assign frame_done   = frame_done_r;

endmodule

// File: tb/tb_display_7seg_scan.sv
// Bench for display_7seg_scan: a 10-bit/4-digit/div-1 instance driven from a vector
// table through an expected-frame queue, and a 10-bit/3-digit/div-4 instance for overflow and slow scan.
module tb_display_7seg_scan;

    localparam logic [7:0] S0 = 8'h81, S1 = 8'hCF, S2 = 8'h92, S3 = 8'h86, S4 = 8'hCC;
    localparam logic [7:0] S5 = 8'hA4, S6 = 8'hA0, S7 = 8'h8F, S8 = 8'h80, S9 = 8'h84;
    localparam logic [7:0] SB = 8'hFF, SD = 8'hFE;

    typedef logic [3:0][7:0] frame_t;
    typedef logic [2:0][7:0] frame3_t;
    typedef struct packed {
        logic       ctrl;
        logic [9:0] frec;
        logic [9:0] corr;
        frame_t     seg;
    } vec_t;

    logic       clk_d = 1'b0;
    logic       reset;
    logic [9:0] frec_a, corr_a, frec_b, corr_b;
    logic       ctrl_a, ctrl_b;
    logic [7:0] cod_a, cod_b;
    logic [3:0] dig_a;
    logic [2:0] dig_b;
    logic       fd_a, fd_b;

    int checks = 0;
    int errors = 0;
    frame_t exp_q[$];

    always #5 clk_d = ~clk_d;

    display_7seg_scan #(.DATA_W(10), .NUM_DIG(4), .SCAN_DIV(1)) dut_a (
        .clk_d(clk_d), .reset(reset), .frecuencia(frec_a), .corriente(corr_a),
        .control(ctrl_a), .codificacion(cod_a), .digito(dig_a), .frame_done(fd_a));

    display_7seg_scan #(.DATA_W(10), .NUM_DIG(3), .SCAN_DIV(4)) dut_b (
        .clk_d(clk_d), .reset(reset), .frecuencia(frec_b), .corriente(corr_b),
        .control(ctrl_b), .codificacion(cod_b), .digito(dig_b), .frame_done(fd_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wait_frame_a(input string name);
        int c;
        c = 0;
        do begin
            @(negedge clk_d);
            c++;
        end while (fd_a !== 1'b1 && c < 60);
        chk({name, "_frame_done"}, {31'd0, fd_a}, 32'd1);
    endtask

    task automatic wait_frame_b(input string name);
        int c;
        c = 0;
        do begin
            @(negedge clk_d);
            c++;
        end while (fd_b !== 1'b1 && c < 60);
        chk({name, "_frame_done"}, {31'd0, fd_b}, 32'd1);
    endtask

    // Samples four consecutive scan cycles starting at the current negedge.
    task automatic check_frame_a(input string name, input frame_t e);
        logic [3:0] seen;
        int idx;
        seen = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk_d);
            chk({name, "_onehot"}, {31'd0, $onehot(dig_a)}, 32'd1);
            idx = -1;
            for (int i = 0; i < 4; i++) if (dig_a == (4'b0001 << i)) idx = i;
            if (idx >= 0) begin
                chk($sformatf("%s_d%0d", name, idx), {24'd0, cod_a}, {24'd0, e[idx]});
                seen[idx] = 1'b1;
            end
        end
        chk({name, "_cover"}, {28'd0, seen}, 32'hF);
    endtask

    // Samples 16 cycles: segment/digit agreement every cycle and 4-cycle digit hold.
    task automatic check_frame_b(input string name, input frame3_t e);
        logic [2:0] prev;
        int idx, run;
        bit changed;
        run = 0;
        changed = 1'b0;
        prev = dig_b;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk_d);
            chk({name, "_onehot"}, {31'd0, $onehot(dig_b)}, 32'd1);
            idx = -1;
            for (int i = 0; i < 3; i++) if (dig_b == (3'b001 << i)) idx = i;
            if (idx >= 0) chk($sformatf("%s_d%0d", name, idx), {24'd0, cod_b}, {24'd0, e[idx]});
            if (k > 0 && dig_b != prev) begin
                if (changed) chk({name, "_hold"}, run, 32'd4);
                changed = 1'b1;
                run = 1;
            end else begin
                run++;
            end
            prev = dig_b;
        end
    endtask

    initial begin
        vec_t    vecs[8];
        frame3_t exp_b[4];
        logic [9:0] val_b[4];
        int cyc;

        vecs[0] = '{1'b1, 10'd125,  10'd0,    {SB, S1, S2, S5}};
        vecs[1] = '{1'b0, 10'd125,  10'd1000, {S1, S0, S0, S0}};
        vecs[2] = '{1'b0, 10'd0,    10'd0,    {SB, SB, SB, S0}};
        vecs[3] = '{1'b1, 10'd1023, 10'd0,    {S1, S0, S2, S3}};
        vecs[4] = '{1'b0, 10'd0,    10'd9,    {SB, SB, SB, S9}};
        vecs[5] = '{1'b0, 10'd0,    10'd10,   {SB, SB, S1, S0}};
        vecs[6] = '{1'b0, 10'd0,    10'd100,  {SB, S1, S0, S0}};
        vecs[7] = '{1'b1, 10'd468,  10'd3,    {SB, S4, S6, S8}};
        val_b[0] = 10'd1023; exp_b[0] = {SD, SD, SD};
        val_b[1] = 10'd999;  exp_b[1] = {S9, S9, S9};
        val_b[2] = 10'd1000; exp_b[2] = {SD, SD, SD};
        val_b[3] = 10'd120;  exp_b[3] = {S1, S2, S0};

        reset = 1'b0;
        frec_a = 10'd0; corr_a = 10'd0; ctrl_a = 1'b0;
        frec_b = 10'd0; corr_b = 10'd0; ctrl_b = 1'b0;
        repeat (3) @(negedge clk_d);
        chk("rst_cod_a", {24'd0, cod_a}, {24'd0, SB});
        chk("rst_dig_a", {28'd0, dig_a}, 32'd0);
        chk("rst_fd_a", {31'd0, fd_a}, 32'd0);
        chk("rst_cod_b", {24'd0, cod_b}, {24'd0, SB});
        chk("rst_dig_b", {29'd0, dig_b}, 32'd0);
        reset = 1'b1;

        // First scan after release, then latency of the first commit.
        @(negedge clk_d);
        cyc = 0;
        while (fd_a !== 1'b1 && cyc < 40) begin
            if (cyc < 5) begin
                chk($sformatf("first_dig_%0d", cyc), {28'd0, dig_a}, 32'd1 << (cyc % 4));
                chk($sformatf("first_cod_%0d", cyc), {24'd0, cod_a},
                    (cyc % 4 == 0) ? {24'd0, S0} : {24'd0, SB});
            end
            @(negedge clk_d);
            cyc++;
        end
        chk("first_frame_latency", cyc, 32'd12);
        @(negedge clk_d);
        chk("frame_done_pulse_width", {31'd0, fd_a}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            ctrl_a = vecs[i].ctrl;
            frec_a = vecs[i].frec;
            corr_a = vecs[i].corr;
            exp_q.push_back(vecs[i].seg);
            wait_frame_a($sformatf("vec%0d_a", i));
            wait_frame_a($sformatf("vec%0d_b", i));
            check_frame_a($sformatf("vec%0d", i), exp_q.pop_front());
        end

        // control toggled mid-SHIFT: current frame keeps 1000, the next one shows 7.
        ctrl_a = 1'b0; corr_a = 10'd1000; frec_a = 10'd7;
        wait_frame_a("tog_settle1");
        wait_frame_a("tog_settle2");
        repeat (3) @(negedge clk_d);
        ctrl_a = 1'b1;
        exp_q.push_back({S1, S0, S0, S0});
        exp_q.push_back({SB, SB, SB, S7});
        wait_frame_a("tog_old");
        check_frame_a("tog_old", exp_q.pop_front());
        wait_frame_a("tog_new");
        check_frame_a("tog_new", exp_q.pop_front());

        for (int i = 0; i < 4; i++) begin
            corr_b = val_b[i];
            wait_frame_b($sformatf("b%0d_a", i));
            wait_frame_b($sformatf("b%0d_b", i));
            check_frame_b($sformatf("b%0d", i), exp_b[i]);
        end

        // Reset five cycles into SHIFT of a 950 conversion.
        ctrl_a = 1'b0; corr_a = 10'd950;
        exp_q.push_back({SB, S9, S5, S0});
        wait_frame_a("r950_a");
        wait_frame_a("r950_b");
        check_frame_a("r950", exp_q.pop_front());
        wait_frame_a("r950_c");
        repeat (5) @(negedge clk_d);
        reset = 1'b0;
        @(negedge clk_d);
        chk("midrst_cod", {24'd0, cod_a}, {24'd0, SB});
        chk("midrst_dig", {28'd0, dig_a}, 32'd0);
        chk("midrst_fd0", {31'd0, fd_a}, 32'd0);
        @(negedge clk_d);
        chk("midrst_fd1", {31'd0, fd_a}, 32'd0);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_d);
            chk($sformatf("post_dig_%0d", k), {28'd0, dig_a}, 32'd1 << (k % 4));
            chk($sformatf("post_cod_%0d", k), {24'd0, cod_a},
                (k % 4 == 0) ? {24'd0, S0} : {24'd0, SB});
            chk($sformatf("post_fd_%0d", k), {31'd0, fd_a}, 32'd0);
        end
        exp_q.push_back({SB, S9, S5, S0});
        wait_frame_a("post950");
        check_frame_a("post950", exp_q.pop_front());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
